ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage RV32 pipeline. Sits directly downstream of the ID/EX pipeline register, and consumes its ex_alusel, ex_aluop, ex_opv1, ex_opv2, ex_waddr and ex_we outputs. Computes single-cycle logic, shift and arithmetic results combinationally. Runs a 32-iteration radix-2 divider FSM for DIV/DIVU/REM/REMU, and raises a stall request to the pipeline controller while a divide is in progress.

## Interface
- No parameters; widths come from the shared defines (RegBus = 32, RegAddrBus = 5, AluSelBus = 3, AluOpBus = 8).
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alusel_i  in  3  result class: EXE_RES_NOP, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_DIV
- aluop_i  in  8  operation within the class
- opv1_i  in  32  operand 1 (rs1 value)
- opv2_i  in  32  operand 2 (rs2 value or immediate)
- waddr_i  in  5  destination register
- we_i  in  1  register write enable
- flush  in  1  kill the in-flight instruction (branch mispredict or exception)
- waddr_o  out  5  destination to EX/MEM
- we_o  out  1  write enable to EX/MEM
- wdata_o  out  32  result to EX/MEM
- stallreq_o  out  1  stall request to the controller

## Operation
- LOGIC class: AND, OR, XOR.
- SHIFT class: SLL, SRL, SRA. Shift amount is opv2_i[4:0].
- ARITH class: ADD, SUB, SLT (signed), SLTU. All arithmetic is 32-bit modulo; there is no overflow trap.
- NOP class, or any unknown op: wdata_o = 0.
- For non-divide ops, waddr_o and we_o are driven combinationally from waddr_i and we_i.
- Divider FSM states:
  - IDLE: when alusel_i = EXE_RES_DIV and flush = 0, latch operands and go to RUN with count = 0. DIV/REM use magnitudes of the signed operands; DIVU/REMU use operands as is.
  - RUN: one restoring-subtract step per cycle, count += 1. After count = 31 completes, go to DONE.
  - DONE: apply sign fix-up, present the result on wdata_o, return to IDLE on the next edge.
- Sign rules: quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- stallreq_o is 1 in the IDLE acceptance cycle and every RUN cycle, and 0 in DONE.
- The pipeline controller freezes ID/EX while stallreq_o is high, so inputs stay stable for the whole divide.
- While not in DONE, a divide forces we_o = 0. In DONE, we_o = we_i.
- flush in any state: go to IDLE next edge, deassert stallreq_o combinationally, force we_o = 0.
- rst: state = IDLE, count = 0, internal registers = 0.

## Timing
- Non-divide ops: 0-cycle combinational latency; stallreq_o = 0.
- Divide (normal path): acceptance cycle + 32 RUN cycles + 1 DONE cycle = result latched by EX/MEM at the end of cycle 34, counting acceptance as cycle 1.
- A divide in ID/EX immediately after a DONE is accepted in the following IDLE cycle.
- Divides are never accepted directly from DONE.
- Output values during rst: wdata_o = 0, we_o = 0, waddr_o = 0, stallreq_o = 0.

## Configuration
- EX_DIV_EARLY_EN defined: divide by zero, signed overflow and dividend = 0 bypass RUN and go IDLE -> DONE.
  - Latency is 2 cycles; stallreq_o is high only in the acceptance cycle.
- EX_DIV_EARLY_EN undefined: every divide takes the full 34 cycles.
  - Special-case results are produced by the DONE fix-up and are bit-identical to the EX_DIV_EARLY_EN case.

## Test plan
- ADD 0x7FFFFFFF + 1 -> wdata_o = 0x80000000 same cycle; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
- DIV -7 / 2 -> quotient 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. stallreq_o high for exactly 33 cycles; result in cycle 34 with we_o = 1.
- DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100. Latency is 34 cycles without EX_DIV_EARLY_EN and 2 cycles with it.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Assert flush in RUN cycle 10 -> stallreq_o drops the same cycle, we_o = 0, FSM in IDLE next cycle. A following DIVU 9 / 3 returns 3.
- Assert rst during RUN -> all outputs 0 and FSM in IDLE after the edge. Back-to-back divides each get a separate acceptance cycle.

Source files
------------

// File: rtl/ex_stage_if.sv
// Operand/result bundle between the ID/EX register, the execute stage and EX/MEM.
interface ex_stage_if;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] opv1_i;
  logic [31:0] opv2_i;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic        flush;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  modport master (
    output alusel_i, aluop_i, opv1_i, opv2_i, waddr_i, we_i, flush,
    input  waddr_o, we_o, wdata_o, stallreq_o
  );

  modport slave (
    input  alusel_i, aluop_i, opv1_i, opv2_i, waddr_i, we_i, flush,
    output waddr_o, we_o, wdata_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: combinational logic/shift/arith plus a 32-step restoring divider.
// Define EX_DIV_EARLY_EN to let trivial divides (x/0, overflow, 0/x) skip the RUN phase.
module ex_stage (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave ex
);
  // state  | meaning
  // IDLE   | no divide in flight; accepts a divide from ID/EX
  // RUN    | one restoring-subtract step per cycle, count 0..31
  // DONE   | signed fix-up applied, result presented for one cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [2:0] EXE_RES_ARITH = 3'd3;
  localparam logic [2:0] EXE_RES_DIV   = 3'd4;

  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_SLL_OP  = 8'h7c;
  localparam logic [7:0] EXE_SRL_OP  = 8'h02;
  localparam logic [7:0] EXE_SRA_OP  = 8'h03;
  localparam logic [7:0] EXE_ADD_OP  = 8'h20;
  localparam logic [7:0] EXE_SUB_OP  = 8'h22;
  localparam logic [7:0] EXE_SLT_OP  = 8'h2a;
  localparam logic [7:0] EXE_SLTU_OP = 8'h2b;
  localparam logic [7:0] EXE_DIV_OP  = 8'h1a;
  localparam logic [7:0] EXE_DIVU_OP = 8'h1b;
  localparam logic [7:0] EXE_REM_OP  = 8'h1c;
  localparam logic [7:0] EXE_REMU_OP = 8'h1d;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] rq;
  logic [31:0] divisor;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic [7:0]  op_r;

  logic        is_div;
  logic        signed_in;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] diff;
  logic [63:0] rq_next;
  logic [31:0] alu_res;
  logic [31:0] div_res;

  assign is_div    = (ex.alusel_i == EXE_RES_DIV);
  assign signed_in = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_REM_OP);
  assign mag1      = (signed_in && ex.opv1_i[31]) ? -ex.opv1_i : ex.opv1_i;
  assign mag2      = (signed_in && ex.opv2_i[31]) ? -ex.opv2_i : ex.opv2_i;

  // Partial remainder is 33 bits after the shift; bit 32 of diff is the borrow.
  assign diff    = rq[63:31] - {1'b0, divisor};
  assign rq_next = diff[32] ? {rq[62:0], 1'b0} : {diff[31:0], rq[30:0], 1'b1};

`ifdef EX_DIV_EARLY_EN
  logic special_in;
  assign special_in = (ex.opv2_i == 32'h0) || (ex.opv1_i == 32'h0) ||
                      (signed_in && ex.opv1_i == 32'h8000_0000 && ex.opv2_i == 32'hffff_ffff);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 5'd0;
      rq      <= 64'h0;
      divisor <= 32'h0;
      op1_r   <= 32'h0;
      op2_r   <= 32'h0;
      op_r    <= 8'h0;
    end else if (ex.flush) begin
      state <= S_IDLE;
      count <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            op_r    <= ex.aluop_i;
            op1_r   <= ex.opv1_i;
            op2_r   <= ex.opv2_i;
            divisor <= mag2;
            rq      <= {32'h0, mag1};
            count   <= 5'd0;
`ifdef EX_DIV_EARLY_EN
            state   <= special_in ? S_DONE : S_RUN;
`else
            state   <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          rq    <= rq_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Special cases override the iterative result so both build options agree bit for bit.
  always_comb begin
    logic        signed_r;
    logic        rem_r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    signed_r = (op_r == EXE_DIV_OP) || (op_r == EXE_REM_OP);
    rem_r    = (op_r == EXE_REM_OP) || (op_r == EXE_REMU_OP);
    q_fix    = (signed_r && (op1_r[31] ^ op2_r[31])) ? -rq[31:0] : rq[31:0];
    r_fix    = (signed_r && op1_r[31]) ? -rq[63:32] : rq[63:32];
    if (op2_r == 32'h0) begin
      q_fix = 32'hffff_ffff;
      r_fix = op1_r;
    end else if (signed_r && op1_r == 32'h8000_0000 && op2_r == 32'hffff_ffff) begin
      q_fix = 32'h8000_0000;
      r_fix = 32'h0;
    end else if (op1_r == 32'h0) begin
      q_fix = 32'h0;
      r_fix = 32'h0;
    end
    div_res = rem_r ? r_fix : q_fix;
  end

  always_comb begin
    alu_res = 32'h0;
    case (ex.alusel_i)
      EXE_RES_LOGIC: begin
        case (ex.aluop_i)
          EXE_AND_OP: alu_res = ex.opv1_i & ex.opv2_i;
          EXE_OR_OP:  alu_res = ex.opv1_i | ex.opv2_i;
          EXE_XOR_OP: alu_res = ex.opv1_i ^ ex.opv2_i;
          default:    alu_res = 32'h0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (ex.aluop_i)
          EXE_SLL_OP: alu_res = ex.opv1_i << ex.opv2_i[4:0];
          EXE_SRL_OP: alu_res = ex.opv1_i >> ex.opv2_i[4:0];
          EXE_SRA_OP: alu_res = $signed(ex.opv1_i) >>> ex.opv2_i[4:0];
          default:    alu_res = 32'h0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (ex.aluop_i)
          EXE_ADD_OP:  alu_res = ex.opv1_i + ex.opv2_i;
          EXE_SUB_OP:  alu_res = ex.opv1_i - ex.opv2_i;
          EXE_SLT_OP:  alu_res = {31'h0, $signed(ex.opv1_i) < $signed(ex.opv2_i)};
          EXE_SLTU_OP: alu_res = {31'h0, ex.opv1_i < ex.opv2_i};
          default:     alu_res = 32'h0;
        endcase
      end
      EXE_RES_NOP: alu_res = 32'h0;
      default:     alu_res = 32'h0;
    endcase
  end

  always_comb begin
    ex.waddr_o    = rst ? 5'h0 : ex.waddr_i;
    ex.wdata_o    = 32'h0;
    ex.we_o       = 1'b0;
    ex.stallreq_o = 1'b0;
    if (!rst) begin
      if (is_div) ex.wdata_o = (state == S_DONE) ? div_res : 32'h0;
      else        ex.wdata_o = alu_res;
      if (!ex.flush) begin
        ex.we_o       = is_div ? (state == S_DONE && ex.we_i) : ex.we_i;
        ex.stallreq_o = (state == S_IDLE && is_div) || (state == S_RUN);
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2,
                         RES_ARITH = 3'd3, RES_DIV = 3'd4;
  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26,
                         OP_SLL = 8'h7c, OP_SRL = 8'h02, OP_SRA = 8'h03,
                         OP_ADD = 8'h20, OP_SUB = 8'h22, OP_SLT = 8'h2a, OP_SLTU = 8'h2b,
                         OP_DIV = 8'h1a, OP_DIVU = 8'h1b, OP_REM = 8'h1c, OP_REMU = 8'h1d;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic we);
    bus.alusel_i = sel;
    bus.aluop_i  = op;
    bus.opv1_i   = a;
    bus.opv2_i   = b;
    bus.waddr_i  = wa;
    bus.we_i     = we;
    bus.flush    = 1'b0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if (sel == RES_LOGIC) begin
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
    end else if (sel == RES_SHIFT) begin
      if (op == OP_SLL) return a << sh;
      if (op == OP_SRL) return a >> sh;
      if (op == OP_SRA) return $unsigned($signed(a) >>> sh);
    end else if (sel == RES_ARITH) begin
      if (op == OP_ADD)  return a + b;
      if (op == OP_SUB)  return a - b;
      if (op == OP_SLT)  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op == OP_SLTU) return (a < b) ? 32'd1 : 32'd0;
    end
    return 32'h0;
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [31:0] ref_div(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 0) begin
      q = 32'hffff_ffff; r = a;
    end else if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      q = 32'h8000_0000; r = 0;
    end else if (is_signed_op(op)) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return (op == OP_REM || op == OP_REMU) ? r : q;
  endfunction

  function automatic int ref_latency(input logic [7:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef EX_DIV_EARLY_EN
    if (b == 0 || a == 0 || (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hffff_ffff))
      return 2;
`endif
    return 34;
  endfunction

  task automatic run_comb(input string tag, input logic [2:0] sel, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wa;
    logic we;
    wa = 5'($urandom_range(0, 31));
    we = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    drive(sel, op, a, b, wa, we);
    @(negedge clk);
    chk({tag, "_wdata"}, bus.wdata_o, ref_alu(sel, op, a, b));
    chk({tag, "_we"}, {31'h0, bus.we_o}, {31'h0, we});
    chk({tag, "_waddr"}, {27'h0, bus.waddr_o}, {27'h0, wa});
    chk({tag, "_stall"}, {31'h0, bus.stallreq_o}, 32'h0);
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [4:0] wa;
    logic we;
    int cyc, stalls, we_leak;
    logic done;
    wa = 5'($urandom_range(0, 31));
    we = ($urandom_range(0, 3) != 0);
    cyc = 0; stalls = 0; we_leak = 0; done = 1'b0;
    @(posedge clk); #1;
    drive(RES_DIV, op, a, b, wa, we);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.stallreq_o) begin
        stalls++;
        if (bus.we_o) we_leak++;
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, "_latency"}, cyc, ref_latency(op, a, b));
    chk({tag, "_stalls"}, stalls, ref_latency(op, a, b) - 1);
    chk({tag, "_we_early"}, we_leak, 0);
    chk({tag, "_wdata"}, bus.wdata_o, ref_div(op, a, b));
    chk({tag, "_we"}, {31'h0, bus.we_o}, {31'h0, we});
    chk({tag, "_waddr"}, {27'h0, bus.waddr_o}, {27'h0, wa});
  endtask

  initial begin
    logic [7:0] cls_ops [4][];
    logic [7:0] div_ops [4];
    cls_ops[0] = '{8'h00};
    cls_ops[1] = '{OP_AND, OP_OR, OP_XOR};
    cls_ops[2] = '{OP_SLL, OP_SRL, OP_SRA};
    cls_ops[3] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU};
    div_ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    drive(RES_DIV, OP_DIV, 32'd5, 32'd3, 5'd7, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_wdata", bus.wdata_o, 32'h0);
    chk("rst_we", {31'h0, bus.we_o}, 32'h0);
    chk("rst_waddr", {27'h0, bus.waddr_o}, 32'h0);
    chk("rst_stall", {31'h0, bus.stallreq_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(RES_NOP, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;

    run_comb("add_wrap", RES_ARITH, OP_ADD, 32'h7fff_ffff, 32'h1);
    run_comb("sra", RES_SHIFT, OP_SRA, 32'h8000_0000, 32'd4);
    run_comb("sltu", RES_ARITH, OP_SLTU, 32'h1, 32'hffff_ffff);
    run_comb("nop", RES_NOP, OP_ADD, 32'h1234, 32'h5678);
    run_comb("unk_op", RES_LOGIC, OP_ADD, 32'hffff, 32'hff);

    for (int i = 0; i < 30; i++) begin
      int c;
      logic [7:0] op;
      logic [2:0] sel;
      c = $urandom_range(0, 3);
      sel = 3'(c);
      op = cls_ops[c][$urandom_range(0, cls_ops[c].size() - 1)];
      if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) sel = 3'd7;
      run_comb("rand_alu", sel, op, $urandom, $urandom);
    end

    run_div("div_neg", OP_DIV, 32'hffff_fff9, 32'd2);
    run_div("rem_neg", OP_REM, 32'hffff_fff9, 32'd2);
    run_div("divu_zero", OP_DIVU, 32'd100, 32'd0);
    run_div("remu_zero", OP_REMU, 32'd100, 32'd0);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hffff_ffff);
    run_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hffff_ffff);
    run_div("div_zero_neg", OP_DIV, 32'hffff_fff0, 32'd0);
    run_div("divu_big", OP_DIVU, 32'hffff_ffff, 32'd1);

    // Flush in RUN cycle 10 (overall cycle 11); the next divide must start from IDLE.
    @(posedge clk); #1;
    drive(RES_DIV, OP_DIV, 32'd1000, 32'd7, 5'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_flush_stall", {31'h0, bus.stallreq_o}, 32'h1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {31'h0, bus.stallreq_o}, 32'h0);
    chk("flush_we", {31'h0, bus.we_o}, 32'h0);
    run_div("after_flush", OP_DIVU, 32'd9, 32'd3);

    // Reset mid-divide.
    @(posedge clk); #1;
    drive(RES_DIV, OP_DIVU, 32'd12345, 32'd17, 5'd9, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_run_wdata", bus.wdata_o, 32'h0);
    chk("rst_run_we", {31'h0, bus.we_o}, 32'h0);
    chk("rst_run_waddr", {27'h0, bus.waddr_o}, 32'h0);
    chk("rst_run_stall", {31'h0, bus.stallreq_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(RES_NOP, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_stall", {31'h0, bus.stallreq_o}, 32'h0);
    run_div("post_rst", OP_DIVU, 32'd12345, 32'd17);

    // Back-to-back divides, each must get its own acceptance cycle.
    run_div("b2b_a", OP_REMU, 32'd50, 32'd7);
    run_div("b2b_b", OP_REMU, 32'd50, 32'd7);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      logic [7:0] op;
      int k;
      op = div_ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 32'h0;
      else if (k == 1) begin a = 32'h8000_0000; b = 32'hffff_ffff; end
      else if (k == 2) a = 32'h0;
      else if (k == 3) b = 32'($urandom_range(1, 15));
      else if (k == 4) b = -32'($urandom_range(1, 15));
      run_div("rand_div", op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
